dlatch_monitor: RTL

DLATCH_MONITOR -- requirements
Module: dlatch_monitor

---
 rtl/dlatch_pkg.sv | 34 +++
 rtl/dlatch_ref_model.sv | 53 +++++
 rtl/dlatch_monitor.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/dlatch_pkg.sv
// -----------------------------------------------------------------------------
// dlatch_pkg
// Shared definitions for the D-latch monitor: FSM state encoding, first-error
// cause codes and a helper that turns the two per-sample violation flags into
// a cause code.
// -----------------------------------------------------------------------------
package dlatch_pkg;

    // Monitor FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // First-error cause codes
    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_Q    = 2'b01;  // q differs from expected value
    localparam logic [1:0] ERR_NQ   = 2'b10;  // nq is not the complement of q
    localparam logic [1:0] ERR_BOTH = 2'b11;  // both at once

    // Map the two violation flags of one sample onto a cause code
    function automatic logic [1:0] encode_err(input logic q_mis, input logic comp_viol);
        logic [1:0] code;
        case ({comp_viol, q_mis})
            2'b01:   code = ERR_Q;
            2'b10:   code = ERR_NQ;
            2'b11:   code = ERR_BOTH;
            default: code = ERR_NONE;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/dlatch_ref_model.sv
// -----------------------------------------------------------------------------
// dlatch_ref_model
// Behavioural model of an ideal transparent-high D latch. It remembers the last
// value written while enable was high (exp_q) and whether any write has
// happened in the current run (known). Before the first write the latch
// content is unknown, so q cannot be checked while enable is low.
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   clear        run entry: forget stored value and known flag
//   sample       a sample is taken on this edge; update the model
//   d, e         data and enable applied to the latch under test
//   exp_val      expected q for the current sample
//   check_valid  high when exp_val is meaningful (e=1 or value known)
// -----------------------------------------------------------------------------
module dlatch_ref_model
    import dlatch_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic sample,
    input  logic d,
    input  logic e,
    output logic exp_val,
    output logic check_valid
);

    logic exp_q_r;
    logic known_r;

    // Model state: cleared on reset and run entry, written while enable is high
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_q_r <= 1'b0;
            known_r <= 1'b0;
        end else if (clear) begin
            exp_q_r <= 1'b0;
            known_r <= 1'b0;
        end else if (sample && e) begin
            exp_q_r <= d;
            known_r <= 1'b1;
        end else begin
            exp_q_r <= exp_q_r;
            known_r <= known_r;
        end
    end

    // A transparent latch follows d while enabled, otherwise shows its content
    assign exp_val     = e ? d : exp_q_r;
    assign check_valid = e | known_r;

endmodule

// File: rtl/dlatch_monitor.sv
// -----------------------------------------------------------------------------
// dlatch_monitor
// Runs a check of N_SAMPLES clocked samples against a D latch under test.
// A start pulse (from IDLE or DONE) clears all results and begins a run; every
// following rising edge takes one sample, compares q with the reference model
// and nq with ~q, and updates the registered results. The edge that takes the
// last sample moves the FSM to DONE, where results are held until the next
// start.
//
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           single-cycle pulse starting a run (ignored during RUN)
//   d, e, q, nq     stimulus and responses of the latch under test
//   busy            run in progress
//   done            run finished, held until next start
//   err             sticky: at least one failing sample in this run
//   err_cnt         number of failing samples, saturating at all-ones
//   first_err_code  cause of first failure (01 q, 10 nq, 11 both)
//   first_err_idx   0-based sample index of first failure
// -----------------------------------------------------------------------------
module dlatch_monitor
    import dlatch_pkg::*;
#(
    parameter int N_SAMPLES = 6,
    parameter int CNT_W     = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             d,
    input  logic             e,
    input  logic             q,
    input  logic             nq,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       first_err_code,
    output logic [15:0]      first_err_idx
);

    localparam logic [15:0] LAST_IDX = 16'(N_SAMPLES - 1);

    state_t           state_r;
    state_t           state_s;
    logic [15:0]      idx_r;
    logic             busy_r;
    logic             done_r;
    logic             err_r;
    logic [CNT_W-1:0] cnt_r;
    logic [1:0]       code_r;
    logic [15:0]      first_idx_r;

    logic             sample_s;
    logic             last_s;
    logic             enter_s;
    logic             exp_val_s;
    logic             check_valid_s;
    logic             q_mis_s;
    logic             comp_viol_s;
    logic             fail_s;

    // Error counter increment that sticks at all-ones
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (&v) begin
            r = v;
        end else begin
            r = v + CNT_W'(1);
        end
        return r;
    endfunction

    assign sample_s = (state_r == ST_RUN);
    assign last_s   = sample_s && (idx_r == LAST_IDX);
    // Run entry from IDLE or DONE; start while running never gets here
    assign enter_s  = (state_s == ST_RUN) && (state_r != ST_RUN);

    dlatch_ref_model u_ref (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (enter_s),
        .sample      (sample_s),
        .d           (d),
        .e           (e),
        .exp_val     (exp_val_s),
        .check_valid (check_valid_s)
    );

    // Per-sample violation detection
    assign q_mis_s     = check_valid_s && (q != exp_val_s);
    assign comp_viol_s = (nq == q);
    assign fail_s      = q_mis_s | comp_viol_s;

    // Next-state logic; the last sample wins over a coincident start
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_s = ST_RUN;
                else       state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_s = ST_RUN;
                else       state_s = ST_DONE;
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Status flags track the state being entered so they are fully registered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_s == ST_RUN);
            done_r <= (state_s == ST_DONE);
        end
    end

    // Sample index and error results; first-error fields freeze once err is set
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_r       <= 16'd0;
            err_r       <= 1'b0;
            cnt_r       <= '0;
            code_r      <= ERR_NONE;
            first_idx_r <= 16'd0;
        end else if (enter_s) begin
            idx_r       <= 16'd0;
            err_r       <= 1'b0;
            cnt_r       <= '0;
            code_r      <= ERR_NONE;
            first_idx_r <= 16'd0;
        end else if (sample_s) begin
            if (!last_s) begin
                idx_r <= idx_r + 16'd1;
            end else begin
                idx_r <= idx_r;
            end
            if (fail_s) begin
                cnt_r <= sat_inc(cnt_r);
                err_r <= 1'b1;
                if (!err_r) begin
                    code_r      <= encode_err(q_mis_s, comp_viol_s);
                    first_idx_r <= idx_r;
                end else begin
                    code_r      <= code_r;
                    first_idx_r <= first_idx_r;
                end
            end else begin
                cnt_r       <= cnt_r;
                err_r       <= err_r;
                code_r      <= code_r;
                first_idx_r <= first_idx_r;
            end
        end else begin
            idx_r       <= idx_r;
            err_r       <= err_r;
            cnt_r       <= cnt_r;
            code_r      <= code_r;
            first_idx_r <= first_idx_r;
        end
    end

    assign busy           = busy_r;
    assign done           = done_r;
    assign err            = err_r;
    assign err_cnt        = cnt_r;
    assign first_err_code = code_r;
    assign first_err_idx  = first_idx_r;

endmodule
